// File: rtl/led_driver_pkg.sv
// Shared types and default WS2812 timing for the LED driver (20 MHz clock).
package led_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

  localparam int PIXEL_BITS = 24;

  // Default bit timing in clk cycles at 20 MHz.
  localparam int DEF_T0H    = 8;
  localparam int DEF_T1H    = 16;
  localparam int DEF_TBIT   = 25;
  localparam int DEF_TLATCH = 1000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_driver_if.sv
// Frame request / serial output bundle of the LED driver.
interface led_driver_if #(
  parameter int NUM_LEDS = 1
);
  logic [NUM_LEDS*24-1:0] inData;
  logic                   start;
  logic                   led;
  logic                   finish;

  modport master (output inData, output start, input led, input finish);
  modport slave  (input inData, input start, output led, output finish);
endinterface

// File: rtl/led_bit_timer.sv
// Generates one WS2812 bit waveform per go strobe; done marks the last cycle of the bit.
module led_bit_timer #(
  parameter int T0H  = 8,
  parameter int T1H  = 16,
  parameter int TBIT = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic go,
  input  logic bit_in,
  output logic led,
  output logic done
);
  localparam int PW = $clog2(TBIT + 1);

  logic [PW-1:0] cnt;
  logic [PW-1:0] cnt_nxt;
  logic [PW-1:0] high;
  logic          busy;
  logic          bitv;
  logic          led_q;

  assign cnt_nxt = cnt + PW'(1);
  assign high    = bitv ? PW'(T1H) : PW'(T0H);
  // cnt is the index of the cycle currently on the line.
  assign done    = busy && (cnt == PW'(TBIT - 1));
  assign led     = led_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      bitv  <= 1'b0;
      cnt   <= '0;
      led_q <= 1'b0;
    end else if (go) begin
      // A go on the done cycle restarts immediately, so bits abut with no gap.
      busy  <= 1'b1;
      bitv  <= bit_in;
      cnt   <= '0;
      led_q <= 1'b1;
    end else if (busy) begin
      if (done) begin
        busy  <= 1'b0;
        cnt   <= '0;
        led_q <= 1'b0;
      end else begin
        cnt   <= cnt_nxt;
        led_q <= (cnt_nxt < high);
      end
    end
  end

endmodule

// File: rtl/led_driver.sv
// WS2812 frame serialiser: captures NUM_LEDS pixels on start, shifts them out MSB first,
// then holds the line low for the latch gap and pulses finish.
module led_driver
  import led_driver_pkg::*;
#(
  parameter int NUM_LEDS = 1,
  parameter int T0H      = DEF_T0H,
  parameter int T1H      = DEF_T1H,
  parameter int TBIT     = DEF_TBIT,
  parameter int TLATCH   = DEF_TLATCH
) (
  input  logic            clk,
  input  logic            reset,
  led_driver_if.slave     bus
);
  localparam int NBITS = NUM_LEDS * PIXEL_BITS;
  localparam int BW    = $clog2(NBITS + 1);
  localparam int CW    = $clog2(max_int(TBIT, TLATCH) + 1);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] SEND  = ST_SEND;
  localparam logic [1:0] LATCH = ST_LATCH;

  if (NUM_LEDS < 1) begin : g_bad_num_leds
    $error("led_driver: NUM_LEDS must be at least 1");
  end
  if (!(T0H > 0 && T0H < T1H && T1H < TBIT)) begin : g_bad_bit_timing
    $error("led_driver: bit timing must satisfy 0 < T0H < T1H < TBIT");
  end
  if (TLATCH < 1) begin : g_bad_latch
    $error("led_driver: TLATCH must be at least 1");
  end

  logic [1:0]       state;
  logic [NBITS-1:0] sreg;
  logic [BW-1:0]    bit_cnt;
  logic [CW-1:0]    cyc_cnt;
  logic             finish_q;
  logic             go;
  logic             bit_in;
  logic             bit_done;
  logic             led_w;

  // sreg[NBITS-1] is always the bit currently being sent; the next one sits just below it.
  assign bit_in = (state == IDLE) ? bus.inData[NBITS-1] : sreg[NBITS-2];
  assign go     = ((state == IDLE) && bus.start) ||
                  ((state == SEND) && bit_done && (bit_cnt != BW'(NBITS)));

  led_bit_timer #(
    .T0H  (T0H),
    .T1H  (T1H),
    .TBIT (TBIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst_n  (reset),
    .go     (go),
    .bit_in (bit_in),
    .led    (led_w),
    .done   (bit_done)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; the shift register is ordinary flops and is cleared with the rest.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      sreg     <= '0;
      bit_cnt  <= '0;
      cyc_cnt  <= '0;
      finish_q <= 1'b0;
    end else begin
      finish_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sreg    <= bus.inData;
            bit_cnt <= BW'(1);
            state   <= SEND;
          end
        end
        SEND: begin
          if (bit_done) begin
            if (bit_cnt == BW'(NBITS)) begin
              state   <= LATCH;
              cyc_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              sreg    <= sreg << 1;
            end
          end
        end
        LATCH: begin
          // finish is raised together with the return to IDLE, so a start seen in that
          // same cycle launches the next frame right after the latch gap.
          if (cyc_cnt == CW'(TLATCH - 1)) begin
            state    <= IDLE;
            finish_q <= 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.led    = led_w;
  assign bus.finish = finish_q;

endmodule

// File: tb/tb_led_driver.sv
// Directed bench for led_driver: one-pixel and two-pixel instances sharing clock and reset.
module tb_led_driver;

  localparam int HI1   = 16;
  localparam int HI0   = 8;
  localparam int BITP  = 25;
  localparam int LATCH = 1000;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  led_driver_if #(.NUM_LEDS(1)) if1 ();
  led_driver_if #(.NUM_LEDS(2)) if2 ();

  led_driver #(.NUM_LEDS(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.slave)
  );

  led_driver #(.NUM_LEDS(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (if2.slave)
  );

  // 20 MHz: posedges at 25 + 50k ns, sampling on negedges.
  initial clk = 1'b0;
  always #25 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic get_led(input int sel);
    return (sel == 2) ? if2.led : if1.led;
  endfunction

  function automatic logic get_fin(input int sel);
    return (sel == 2) ? if2.finish : if1.finish;
  endfunction

  task automatic frame_start(input int sel, input logic [47:0] data, input bit hold);
    @(negedge clk);
    if (sel == 2) begin
      if2.inData = data;
      if2.start  = 1'b1;
    end else begin
      if1.inData = data[23:0];
      if1.start  = 1'b1;
    end
    @(negedge clk);
    if (!hold) begin
      if1.start = 1'b0;
      if2.start = 1'b0;
    end
  endtask

  // Entered at the negedge of cycle 0 after capture; returns at the negedge one cycle
  // after the finish pulse.
  task automatic check_frame(input int sel, input logic [47:0] data, input int nbits,
                             input string name);
    int fin_seen;
    int hi_cnt;
    fin_seen = 0;
    hi_cnt   = 0;
    for (int b = 0; b < nbits; b++) begin
      logic [BITP-1:0] obs;
      logic [BITP-1:0] exp;
      logic            bv;
      bv = data[nbits-1-b];
      for (int c = 0; c < BITP; c++) begin
        exp[BITP-1-c] = (c < (bv ? HI1 : HI0));
        obs[BITP-1-c] = get_led(sel);
        if (get_fin(sel)) fin_seen++;
        @(negedge clk);
      end
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s bit %0d: led got %b expected %b", name, b, obs, exp);
      end
    end
    for (int c = 0; c < LATCH; c++) begin
      if (get_led(sel) !== 1'b0) hi_cnt++;
      if (get_fin(sel)) fin_seen++;
      @(negedge clk);
    end
    checks++;
    if (hi_cnt != 0) begin
      errors++;
      $display("FAIL %s latch_low: led high cycles got %0d expected 0", name, hi_cnt);
    end
    checks++;
    if (fin_seen != 0) begin
      errors++;
      $display("FAIL %s early_finish: finish cycles got %0d expected 0", name, fin_seen);
    end
    checks++;
    if (get_fin(sel) !== 1'b1) begin
      errors++;
      $display("FAIL %s finish_pulse: finish got %b expected 1", name, get_fin(sel));
    end
    checks++;
    if (get_led(sel) !== 1'b0) begin
      errors++;
      $display("FAIL %s led_at_finish: led got %b expected 0", name, get_led(sel));
    end
    @(negedge clk);
    checks++;
    if (get_fin(sel) !== 1'b0) begin
      errors++;
      $display("FAIL %s finish_width: finish got %b expected 0", name, get_fin(sel));
    end
  endtask

  task automatic check_quiet(input int sel, input int ncyc, input string name);
    int bad;
    bad = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (get_led(sel) !== 1'b0 || get_fin(sel) !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s quiet: active cycles got %0d expected 0", name, bad);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #200ns;
    checks++;
    if (if1.led !== 1'b0 || if1.finish !== 1'b0) begin
      errors++;
      $display("FAIL reset_dut1: led/finish got %b%b expected 00", if1.led, if1.finish);
    end
    checks++;
    if (if2.led !== 1'b0 || if2.finish !== 1'b0) begin
      errors++;
      $display("FAIL reset_dut2: led/finish got %b%b expected 00", if2.led, if2.finish);
    end
    @(negedge clk);
    reset = 1'b1;
    check_quiet(1, 100, "idle_after_reset_dut1");
    check_quiet(2, 20, "idle_after_reset_dut2");
  endtask

  task automatic test_single_msb;
    frame_start(1, 48'h800000, 1'b0);
    check_frame(1, 48'h800000, 24, "msb_only");
  endtask

  task automatic test_all_ones_zeros;
    frame_start(1, 48'hFFFFFF, 1'b0);
    check_frame(1, 48'hFFFFFF, 24, "all_ones");
    frame_start(1, 48'h000000, 1'b0);
    check_frame(1, 48'h000000, 24, "all_zeros");
  endtask

  task automatic test_two_pixels;
    frame_start(2, 48'hAAAAAA_555555, 1'b0);
    check_frame(2, 48'hAAAAAA_555555, 48, "two_pixels");
  endtask

  task automatic test_ignore_start;
    frame_start(1, 48'hA5C3F0, 1'b0);
    fork
      check_frame(1, 48'hA5C3F0, 24, "ignore_start");
      begin
        repeat (137) @(negedge clk);
        #5 if1.inData = 24'h123456;
        if1.start = 1'b1;
        @(negedge clk);
        #5 if1.start = 1'b0;
        repeat (800) @(negedge clk);
        #5 if1.start = 1'b1;
        @(negedge clk);
        #5 if1.start = 1'b0;
      end
    join
    check_quiet(1, 40, "no_second_frame");
  endtask

  task automatic test_back_to_back;
    frame_start(1, 48'hC0FFEE, 1'b1);
    if1.inData = 24'h3C5A96;
    check_frame(1, 48'hC0FFEE, 24, "b2b_first");
    if1.start = 1'b0;
    check_frame(1, 48'h3C5A96, 24, "b2b_second");
    check_quiet(1, 30, "b2b_end");
  endtask

  task automatic test_reset_mid_frame;
    frame_start(1, 48'hFFFFFF, 1'b0);
    repeat (30) @(negedge clk);
    checks++;
    if (if1.led !== 1'b1) begin
      errors++;
      $display("FAIL mid_frame_high: led got %b expected 1", if1.led);
    end
    #10 reset = 1'b0;
    #1;
    checks++;
    if (if1.led !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_led: led got %b expected 0", if1.led);
    end
    checks++;
    if (if1.finish !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_finish: finish got %b expected 0", if1.finish);
    end
    repeat (4) @(negedge clk);
    reset = 1'b1;
    check_quiet(1, 1700, "aborted_frame");
    frame_start(1, 48'h0F0F0F, 1'b0);
    check_frame(1, 48'h0F0F0F, 24, "after_abort");
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    if1.start  = 1'b0;
    if1.inData = '0;
    if2.start  = 1'b0;
    if2.inData = '0;

    test_reset();
    test_single_msb();
    test_all_ones_zeros();
    test_two_pixels();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_frame();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
